// File: rtl/rf_wb_scheduler_pkg.sv
// Shared sizes and types for the register-file writeback scheduler.
// Keep the sizes here in sync with the top-level parameter defaults.
package rf_wb_scheduler_pkg;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 16;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_src_e;

endpackage

// File: rtl/rf_wb_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers the last winner.
// On a tie, the source that did not win last time gets the grant.
module rr_arb2
  import rf_wb_scheduler_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req_a,
  input  logic     req_b,
  output logic     gnt_a,
  output logic     gnt_b,
  output gnt_src_e last_gnt
);

  gnt_src_e last_q;

  // Nothing is granted while reset is applied, so no source sees its request consumed.
  always_comb begin
    gnt_a = ~rst & req_a & (~req_b | (last_q == GNT_B));
    gnt_b = ~rst & req_b & (~req_a | (last_q == GNT_A));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_B;
    end else if (gnt_a) begin
      last_q <= GNT_A;
    end else if (gnt_b) begin
      last_q <= GNT_B;
    end
  end

  assign last_gnt = last_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Scoreboard plus writeback scheduler: blocks issue on RAW/WAW hazards.
// It also merges the ALU and memory writebacks onto the single register-file write port.
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int NREG = rf_wb_scheduler_pkg::NREG,
  parameter int AW   = rf_wb_scheduler_pkg::AW,
  parameter int DW   = rf_wb_scheduler_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wba_valid,
  input  logic [AW-1:0]   wba_rd,
  input  logic [DW-1:0]   wba_data,
  output logic            wba_ready,
  input  logic            wbb_valid,
  input  logic [AW-1:0]   wbb_rd,
  input  logic [DW-1:0]   wbb_data,
  output logic            wbb_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wreg,
  output logic [DW-1:0]   rf_wdata,
  output logic [NREG-1:0] busy,
  output logic            err_spurious
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;
  logic            gnt_a;
  logic            gnt_b;
  gnt_src_e        last_gnt;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic            issue_fire;
  logic            spurious_hit;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_a    (wba_valid),
    .req_b    (wbb_valid),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .last_gnt (last_gnt)
  );

  assign wba_ready = gnt_a;
  assign wbb_ready = gnt_b;
  assign wb_valid  = gnt_a | gnt_b;
  assign wb_rd     = gnt_b ? wbb_rd   : wba_rd;
  assign wb_data   = gnt_b ? wbb_data : wba_data;

  // Hazard check uses registered busy only; a commit in this cycle is not bypassed.
  always_comb begin
    issue_ready = ~(issue_use_rs1 & busy_q[issue_rs1])
                & ~(issue_use_rs2 & busy_q[issue_rs2])
                & ~(issue_we      & busy_q[issue_rd]);
  end

  assign issue_fire = issue_valid & issue_ready & issue_we & (issue_rd != REG_ZERO);

  always_comb begin
    busy_next = busy_q;
    if (rf_we) begin
      busy_next[rf_wreg] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // A register still sitting in rf_wreg was legitimately busy until just now.
  assign spurious_hit = wb_valid & (wb_rd != REG_ZERO) & ~busy_q[wb_rd] & (wb_rd != rf_wreg);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      rf_we        <= 1'b0;
      rf_wreg      <= '0;
      rf_wdata     <= '0;
      err_spurious <= 1'b0;
    end else begin
      busy_q <= busy_next;
      rf_we  <= wb_valid & (wb_rd != REG_ZERO);
      if (wb_valid) begin
        rf_wreg  <= wb_rd;
        rf_wdata <= wb_data;
      end
      if (spurious_hit) begin
        err_spurious <= 1'b1;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler; expected writes are queued as stimulus is driven.
// Each expected write is popped and compared when rf_we appears.
module tb_rf_wb_scheduler;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 16;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid, issue_use_rs1, issue_use_rs2, issue_we;
  logic [AW-1:0]   issue_rs1, issue_rs2, issue_rd;
  logic            issue_ready;
  logic            wba_valid, wbb_valid;
  logic [AW-1:0]   wba_rd, wbb_rd;
  logic [DW-1:0]   wba_data, wbb_data;
  logic            wba_ready, wbb_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_wreg;
  logic [DW-1:0]   rf_wdata;
  logic [NREG-1:0] busy;
  logic            err_spurious;

  int  n_cmp = 0;
  int  n_err = 0;
  wr_t sb[$];
  wr_t exp_w;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_we(issue_we), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wba_valid(wba_valid), .wba_rd(wba_rd), .wba_data(wba_data), .wba_ready(wba_ready),
    .wbb_valid(wbb_valid), .wbb_rd(wbb_rd), .wbb_data(wbb_data), .wbb_ready(wbb_ready),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .busy(busy), .err_spurious(err_spurious)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_we = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    wba_valid = 0; wba_rd = 0; wba_data = 0;
    wbb_valid = 0; wbb_rd = 0; wbb_data = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick(); tick();
    rst = 0;
    n_cmp++; if (busy !== 16'h0000) begin n_err++; $display("FAIL reset_busy got %h want 0000", busy); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
    n_cmp++; if (rf_wreg !== 4'h0) begin n_err++; $display("FAIL reset_rf_wreg got %h want 0", rf_wreg); end
    n_cmp++; if (rf_wdata !== 16'h0000) begin n_err++; $display("FAIL reset_rf_wdata got %h want 0000", rf_wdata); end
    n_cmp++; if (err_spurious !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err_spurious); end
  endtask

  task automatic test_issue_hazard();
    issue_valid = 1; issue_we = 1; issue_rd = 3;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL haz_first_ready got %b want 1", issue_ready); end
    tick();
    issue_we = 0; issue_rd = 0; issue_use_rs1 = 1; issue_rs1 = 3;
    n_cmp++; if (busy !== 16'h0008) begin n_err++; $display("FAIL haz_busy_set got %h want 0008", busy); end
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL haz_stall0 got %b want 0", issue_ready); end
    tick();
    n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL haz_stall1 got %b want 0", issue_ready); end
    wba_valid = 1; wba_rd = 3; wba_data = 16'hAAAA;
    #1;
    n_cmp++; if (wba_ready !== 1'b1) begin n_err++; $display("FAIL haz_wb_ready got %b want 1", wba_ready); end
    sb.push_back('{rd: 4'd3, data: 16'hAAAA});
    tick();
    wba_valid = 0;
    n_cmp++;
    if (rf_we !== 1'b1 || sb.size() == 0) begin
      n_err++; $display("FAIL haz_commit_we got %b want 1", rf_we);
    end else begin
      exp_w = sb.pop_front();
      if (rf_wreg !== exp_w.rd || rf_wdata !== exp_w.data) begin
        n_err++; $display("FAIL haz_commit got %h/%h want %h/%h", rf_wreg, rf_wdata, exp_w.rd, exp_w.data);
      end
    end
    n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL haz_stall_during_we got %b want 0", issue_ready); end
    tick();
    n_cmp++; if (busy !== 16'h0000) begin n_err++; $display("FAIL haz_busy_clear got %h want 0000", busy); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL haz_release got %b want 1", issue_ready); end
    idle();
  endtask

  task automatic test_back_to_back();
    rst = 1; idle(); tick(); rst = 0;
    issue_valid = 1; issue_we = 1; issue_rd = 5; tick();
    issue_rd = 6; tick();
    idle();
    n_cmp++; if (busy !== 16'h0060) begin n_err++; $display("FAIL b2b_busy got %h want 0060", busy); end
    wba_valid = 1; wba_rd = 5; wba_data = 16'h1234;
    wbb_valid = 1; wbb_rd = 6; wbb_data = 16'hBEEF;
    #1;
    n_cmp++; if ({wba_ready, wbb_ready} !== 2'b10) begin n_err++; $display("FAIL b2b_first_gnt got %b want 10", {wba_ready, wbb_ready}); end
    sb.push_back('{rd: 4'd5, data: 16'h1234});
    tick();
    n_cmp++; if ({wba_ready, wbb_ready} !== 2'b01) begin n_err++; $display("FAIL b2b_second_gnt got %b want 01", {wba_ready, wbb_ready}); end
    sb.push_back('{rd: 4'd6, data: 16'hBEEF});
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (rf_we !== 1'b1 || sb.size() == 0) begin
        n_err++; $display("FAIL b2b_we%0d got %b want 1", c, rf_we);
      end else begin
        exp_w = sb.pop_front();
        if (rf_wreg !== exp_w.rd || rf_wdata !== exp_w.data) begin
          n_err++; $display("FAIL b2b_write%0d got %h/%h want %h/%h", c, rf_wreg, rf_wdata, exp_w.rd, exp_w.data);
        end
      end
      tick();
      idle();
    end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL b2b_we_end got %b want 0", rf_we); end
    n_cmp++; if (busy !== 16'h0000) begin n_err++; $display("FAIL b2b_busy_end got %h want 0000", busy); end
  endtask

  task automatic test_rd0();
    issue_valid = 1; issue_we = 1; issue_rd = 0;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rd0_issue_ready got %b want 1", issue_ready); end
    tick();
    idle();
    n_cmp++; if (busy !== 16'h0000) begin n_err++; $display("FAIL rd0_busy got %h want 0000", busy); end
    wba_valid = 1; wba_rd = 0; wba_data = 16'hCAFE;
    #1;
    n_cmp++; if (wba_ready !== 1'b1) begin n_err++; $display("FAIL rd0_wb_ready got %b want 1", wba_ready); end
    tick();
    idle();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rd0_rf_we got %b want 0", rf_we); end
    n_cmp++; if (err_spurious !== 1'b0) begin n_err++; $display("FAIL rd0_err got %b want 0", err_spurious); end
  endtask

  task automatic test_spurious();
    wba_valid = 1; wba_rd = 9; wba_data = 16'h5A5A;
    #1;
    n_cmp++; if (wba_ready !== 1'b1) begin n_err++; $display("FAIL spur_ready got %b want 1", wba_ready); end
    sb.push_back('{rd: 4'd9, data: 16'h5A5A});
    tick();
    idle();
    n_cmp++;
    if (rf_we !== 1'b1 || sb.size() == 0) begin
      n_err++; $display("FAIL spur_we got %b want 1", rf_we);
    end else begin
      exp_w = sb.pop_front();
      if (rf_wreg !== exp_w.rd || rf_wdata !== exp_w.data) begin
        n_err++; $display("FAIL spur_write got %h/%h want %h/%h", rf_wreg, rf_wdata, exp_w.rd, exp_w.data);
      end
    end
    n_cmp++; if (err_spurious !== 1'b1) begin n_err++; $display("FAIL spur_err_set got %b want 1", err_spurious); end
    repeat (3) tick();
    n_cmp++; if (err_spurious !== 1'b1) begin n_err++; $display("FAIL spur_err_sticky got %b want 1", err_spurious); end
  endtask

  task automatic test_concurrent();
    issue_valid = 1; issue_we = 1; issue_rd = 7; tick();
    idle();
    wba_valid = 1; wba_rd = 7; wba_data = 16'h7777;
    sb.push_back('{rd: 4'd7, data: 16'h7777});
    tick();
    idle();
    n_cmp++;
    if (rf_we !== 1'b1 || sb.size() == 0) begin
      n_err++; $display("FAIL conc_we got %b want 1", rf_we);
    end else begin
      exp_w = sb.pop_front();
      if (rf_wreg !== exp_w.rd || rf_wdata !== exp_w.data) begin
        n_err++; $display("FAIL conc_write got %h/%h want %h/%h", rf_wreg, rf_wdata, exp_w.rd, exp_w.data);
      end
    end
    issue_valid = 1; issue_we = 1; issue_rd = 2;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL conc_issue_ready got %b want 1", issue_ready); end
    tick();
    idle();
    n_cmp++; if (busy !== 16'h0004) begin n_err++; $display("FAIL conc_busy got %h want 0004", busy); end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_we = 1;
    for (int r = 1; r < NREG; r++) begin
      issue_rd = r[AW-1:0];
      tick();
    end
    idle();
    n_cmp++; if (busy !== 16'hFFFE) begin n_err++; $display("FAIL rmid_busy_full got %h want fffe", busy); end
    wba_valid = 1; wba_rd = 4; wba_data = 16'h4444;
    #1;
    n_cmp++; if (wba_ready !== 1'b1) begin n_err++; $display("FAIL rmid_pending got %b want 1", wba_ready); end
    rst = 1;
    tick();
    rst = 0;
    idle();
    n_cmp++; if (busy !== 16'h0000) begin n_err++; $display("FAIL rmid_busy got %h want 0000", busy); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rmid_rf_we got %b want 0", rf_we); end
    n_cmp++; if (err_spurious !== 1'b0) begin n_err++; $display("FAIL rmid_err got %b want 0", err_spurious); end
    wba_valid = 1; wba_rd = 0; wbb_valid = 1; wbb_rd = 0;
    #1;
    n_cmp++; if ({wba_ready, wbb_ready} !== 2'b10) begin n_err++; $display("FAIL rmid_ptr got %b want 10", {wba_ready, wbb_ready}); end
    tick();
    idle();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rmid_rd0_we got %b want 0", rf_we); end
  endtask

  initial begin
    test_reset();
    test_issue_hazard();
    test_back_to_back();
    test_rd0();
    test_spurious();
    test_concurrent();
    test_reset_mid();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Register-file writeback scheduler and scoreboard for the 16 x 16-bit register file. It tracks a busy bit per register for issued-but-uncommitted writes and stalls issue on RAW/WAW hazards. It arbitrates two writeback sources (ALU pipe A, memory pipe B) round-robin onto the single register-file write port, and sits between the decode/issue stage and the register file write side.

## Interface
Parameters:
- NREG, 16, number of architectural registers (register 0 hardwired zero)
- AW, 4, register-id width
- DW, 16, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents an instruction
- issue_rs1, issue_rs2  in  AW  source register ids
- issue_use_rs1, issue_use_rs2  in  1  source actually read
- issue_we  in  1  instruction writes a destination
- issue_rd  in  AW  destination id
- issue_ready  out  1  no hazard; issue accepted when valid & ready
- wba_valid, wbb_valid  in  1  writeback request, pipe A / pipe B
- wba_rd, wbb_rd  in  AW  writeback destination
- wba_data, wbb_data  in  DW  writeback value
- wba_ready, wbb_ready  out  1  request granted this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_wreg  out  AW  write address (registered)
- rf_wdata  out  DW  write data (registered)
- busy  out  NREG  scoreboard bits
- err_spurious  out  1  sticky: writeback to a non-busy register (rd != 0)

## Operation
- Reset: busy = 0, rf_we = 0, rf_wreg = 0, rf_wdata = 0, err_spurious = 0, round-robin pointer favors A. Resetting mid-operation drops all pending state and requests with no partial writes.
- issue_ready = ~(issue_use_rs1 & busy[rs1]) & ~(issue_use_rs2 & busy[rs2]) & ~(issue_we & busy[rd]). Evaluated from registered busy only; no same-cycle bypass.
- Accepted issue with issue_we=1 and rd != 0 sets busy[rd] at the edge. rd = 0 never sets busy. busy[0] is constant 0.
- Arbitration: a single valid request is granted. If both are valid, the source not granted last wins. The pointer updates to the winner on every grant. The loser holds its valid/rd/data stable until ready.
- Grant: the winner's rd/data are registered into rf_wreg/rf_wdata and rf_we = (rd != 0) at the next edge. A grant with rd = 0 is consumed but produces rf_we = 0.
- Commit: busy[rf_wreg] clears at the edge ending a cycle with rf_we = 1.
- A writeback to rd != 0 whose busy bit is 0 at grant time and is not the current rf_wreg sets err_spurious. The write still proceeds.

## Timing
- Grant is combinational from valid (ready same cycle). rf_we is asserted 1 cycle after the grant. busy clears 2 edges after the grant edge. A dependent issue is first ready in the cycle after rf_we is high.
- One register-file write per cycle. Back-to-back grants give continuous rf_we.
- Simultaneous set (issue) and clear (commit) of the same register cannot occur, because issue is blocked while busy. Set and clear of different registers in the same cycle both take effect.
- Issue and writeback proceed in the same cycle independently.

## Structure
- The shared package holds NREG, AW, DW, the register-0 constant, and the grant-source enum (GNT_A, GNT_B).
- Sub-module rr_arb2: two-requester round-robin arbiter containing the pointer flop and the grant logic.
- Top-level content: scoreboard flops, hazard compare, output registers, and error flag.

## Test plan
- Reset, then issue rd=3 with no sources: ready=1 and busy = 0x0008 next cycle. A second issue with rs1=3, use_rs1=1 gives ready=0 until the cycle after rf_we=1 with rf_wreg=3.
- wba (rd=5, data=0x1234) and wbb (rd=6, data=0xBEEF) are valid together for 2 cycles after reset. A granted first, then B. rf_we is high for 2 consecutive cycles with (5, 0x1234) then (6, 0xBEEF).
- Issue with rd=0 gives busy unchanged. A writeback with rd=0 gives ready=1, rf_we=0, and err_spurious=0.
- Writeback to rd=9 while busy[9]=0 gives rf_we=1 with rf_wreg=9 and err_spurious=1, which stays 1 until rst.
- Issue rd=2 while committing rd=7 in the same cycle: busy[2]=1 and busy[7]=0 after the edge.
- Assert rst while busy = 0xFFFE and a grant is pending: the next cycle shows busy=0, rf_we=0, and the pointer favoring A.
